// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: state encoding, oversample ratio and
//               parity helper, common to transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Baud-rate oversampling factor: one bit time spans this many s_tick pulses
    localparam int OVERSAMPLE     = 16;

    // Widest data word the parity helper accepts
    localparam int MAX_DATA_WIDTH = 32;

    // Serial frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity of a zero-extended data word; odd = 1 inverts for odd parity
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Host-side write handshake of the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  tx_start;
    logic [DATA_WIDTH-1:0] din;
    logic                  tx_ready;
    logic                  tx_done;

    // Host side: issues write strobes, observes ready/done
    modport master (
        output tx_start,
        output din,
        input  tx_ready,
        input  tx_done
    );

    // Transmitter side
    modport slave (
        input  tx_start,
        input  din,
        output tx_ready,
        output tx_done
    );

endinterface : uart_tx_if
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter with one-entry holding register, optional
//               parity bit and configurable stop length. Bit timing comes from
//               an external 16x oversample enable (s_tick).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic s_tick,
    uart_tx_if.slave  bus,
    output logic      tx
);

    // Tick counter must also cover stop lengths longer than one bit time
    localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [S_W-1:0] C_S_LAST    = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] C_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] C_N_LAST    = N_W'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    logic [S_W-1:0]        s_q;
    logic [N_W-1:0]        n_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_vld_q;
    logic                  par_q;
    logic                  tx_q;
    logic                  done_q;

    logic                  accept;
    logic                  hold_par;
    logic [DATA_WIDTH-1:0] shift_nxt;

    assign accept    = bus.tx_start & ~hold_vld_q;
    // Parity is taken from the held byte so it is ready when the frame loads
    assign hold_par  = calc_parity(MAX_DATA_WIDTH'(hold_q), PARITY_ODD != 0);
    assign shift_nxt = shift_q >> 1;

    assign bus.tx_ready = ~hold_vld_q;
    assign bus.tx_done  = done_q;
    assign tx           = tx_q;

    // Holding register and frame sequencer; all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Acceptance and hand-off to the shifter never coincide: the
            // hand-off needs hold full, acceptance needs it empty.
            if (accept) begin
                hold_q     <= bus.din;
                hold_vld_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (hold_vld_q) begin
                        shift_q    <= hold_q;
                        par_q      <= hold_par;
                        hold_vld_q <= 1'b0;
                        s_q        <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    if (s_tick) begin
                        if (s_q == C_S_LAST) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            tx_q    <= shift_q[0];
                            state_q <= ST_DATA;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (s_tick) begin
                        if (s_q == C_S_LAST) begin
                            s_q     <= '0;
                            shift_q <= shift_nxt;
                            if (n_q == C_N_LAST) begin
                                if (PARITY_EN != 0) begin
                                    tx_q    <= par_q;
                                    state_q <= ST_PARITY;
                                end else begin
                                    tx_q    <= 1'b1;
                                    state_q <= ST_STOP;
                                end
                            end else begin
                                n_q  <= n_q + 1'b1;
                                tx_q <= shift_nxt[0];
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (s_tick) begin
                        if (s_q == C_S_LAST) begin
                            s_q     <= '0;
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (s_tick) begin
                        if (s_q == C_STOP_LAST) begin
                            s_q    <= '0;
                            done_q <= 1'b1;
                            // A byte already waiting starts with no idle bit
                            if (hold_vld_q) begin
                                shift_q    <= hold_q;
                                par_q      <= hold_par;
                                hold_vld_q <= 1'b0;
                                tx_q       <= 1'b0;
                                state_q    <= ST_START;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                default: begin
                    s_q     <= '0;
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx
`default_nettype wire
